punc_control: RTL and testbench
===============================

Name: punc_control

Overview:
- Multicycle control FSM for the PUnC LC3 processor; sits directly upstream of the PUnC datapath and drives every datapath select, load and write-enable.
- Consumes the current instruction register contents and the N/Z/P condition flags from the datapath.
- Sequences fetch, decode and execute for the full LC3 subset, including the two-access indirect loads and stores (LDI, STI).

Parameters:
- none. All encodings are constants in the shared package.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high. One clock; all state changes occur on the rising edge of clk.
- ir  in  16  current instruction from the datapath IR.
- n, z, p  in  1 each  datapath condition flags.
- pc_ld  out  1  load PC from the pc_data_sel source.
- pc_inc  out  1  PC <= PC+1.
- pc_data_sel  out  1  0 = PC adder, 1 = base register (rf_r_data_0).
- pc_add_sel  out  1  PC adder offset: 0 = sext(IR[10:0]), 1 = sext(IR[8:0]).
- ir_ld  out  1  IR <= mem_r_data_0.
- mem_addr_sel  out  2  0 = PC, 1 = ALU result, 2 = store register.
- mem_w_en  out  1  memory write; data is rf_r_data_1.
- store_ld  out  1  store register <= mem_r_data_0.
- rf_r_addr_0, rf_r_addr_1, rf_w_addr  out  3 each  register file addresses.
- rf_w_en  out  1  register file write.
- rf_w_data_sel  out  2  0 = PC, 1 = memory read data, 2 = ALU result.
- alu_a_sel  out  1  0 = PC, 1 = rf_r_data_0.
- alu_b_sel  out  1  0 = rf_r_data_1, 1 = sext result.
- sext_sel  out  2  0 = IR[4:0], 1 = IR[5:0], 2 = IR[8:0], 3 = IR[10:0].
- alu_sel  out  2  0 = ADD, 1 = AND, 2 = NOT A, 3 = PASS A.
- nzp_ld  out  1  load N/Z/P flags.
- nzp_sel  out  1  flag source: 0 = ALU result, 1 = memory read data.
- halted  out  1  high while in the HALT state.
- state_dbg  out  3  current state encoding.

Behaviour:
- Timing: memory read is combinational; memory and register file writes, and all register loads, take effect at the clock edge ending the cycle.
- Outputs are a combinational function of state and ir. Every output not listed below for a state is 0.
- Reset: state = FETCH; halted = 0. With rst high, all outputs are forced to 0 in that cycle. Reset mid-instruction abandons the instruction; no write is issued.
- States: FETCH=0, DECODE=1, EXEC=2, EXEC2=3, HALT=4.
- FETCH: mem_addr_sel=PC, ir_ld=1, pc_inc=1. Next state DECODE.
- DECODE: no outputs. Next state is HALT if ir[15:12]=1111, otherwise EXEC.
- EXEC, by opcode ir[15:12]. PC-relative operations use the already-incremented PC.
  - ADD(0001)/AND(0101): r0=IR[8:6]; r1=IR[2:0]; alu_b_sel=IR[5]; sext_sel=0; write IR[11:9] from ALU; nzp_ld=1 with nzp_sel=ALU.
  - NOT(1001): r0=IR[8:6]; alu_sel=NOT; write IR[11:9] from ALU; nzp_ld=1 with nzp_sel=ALU.
  - BR(0000): if (IR[11]&n)|(IR[10]&z)|(IR[9]&p), then pc_ld=1 with adder source and offset9. A BR with nzp bits 000 is a NOP.
  - JMP/RET(1100): r0=IR[8:6]; pc_ld=1; pc_data_sel=base.
  - JSR/JSRR(0100): rf_w_en=1; w_addr=7; rf_w_data_sel=PC; pc_ld=1. If IR[11]: adder source with offset11. Else: base source with r0=IR[8:6]. JSRR R7 jumps to the old R7, because the read precedes the edge.
  - LD(0010): address = PC+sext9 (a=PC, b=sext, sext_sel=2, ADD, mem_addr_sel=ALU); write IR[11:9] from memory; nzp_ld=1 with nzp_sel=memory.
  - LDR(0110): address = R[IR[8:6]]+sext6; write and flags as for LD.
  - LEA(1110): ALU computes PC+sext9; write IR[11:9] from ALU; flags unchanged.
  - ST(0011): address = PC+sext9; r1=IR[11:9]; mem_w_en=1.
  - STR(0111): address = R[IR[8:6]]+sext6; r1=IR[11:9]; mem_w_en=1.
  - LDI(1010)/STI(1011): address = PC+sext9; store_ld=1; next state EXEC2.
  - RTI(1000) and reserved (1101): NOP.
- Next state after EXEC: FETCH, except LDI/STI go to EXEC2.
- EXEC2: mem_addr_sel=store.
  - LDI: write IR[11:9] from memory; nzp_ld=1 with nzp_sel=memory.
  - STI: r1=IR[11:9]; mem_w_en=1.
  - Next state FETCH.
- HALT: absorbing; only rst exits. halted=1.
- Latency: 3 cycles per instruction; LDI/STI take 4.
- Never asserted together: pc_ld with pc_inc; ir_ld with mem_w_en; more than one of rf_w_en, mem_w_en, store_ld, except JSR, where rf_w_en and pc_ld are simultaneous.
- Undefined state encodings (5-7) return to FETCH.

Decomposition:
- Package punc_ctrl_defs holds:
  - opcode constants;
  - state encodings;
  - encodings for pc_data_sel, pc_add_sel, mem_addr_sel, rf_w_data_sel, alu_a_sel, alu_b_sel, sext_sel, alu_sel, nzp_sel.
- The package is shared with the datapath.
- One sub-module: punc_br_eval, a combinational branch-taken evaluation of ir[11:9] against n/z/p. Everything else stays in one module.

Test Plan:
- rst high for 2 cycles, then release with ir=0x1000 -> FETCH state; all outputs 0 during reset. First cycle after release: ir_ld=1, pc_inc=1, mem_addr_sel=0.
- ir=0x1261 (ADD R1,R1,#1) -> in EXEC: alu_b_sel=1, sext_sel=0, rf_w_en=1, rf_w_addr=1, nzp_ld=1. Back to FETCH after 3 cycles.
- ir=0x0402 (BRz) with z=0 -> pc_ld=0 in EXEC. Same ir with z=1 -> pc_ld=1, pc_add_sel=1.
- ir=0xA005 (LDI R0) -> EXEC asserts store_ld=1 with mem_addr_sel=1. EXEC2 asserts mem_addr_sel=2, rf_w_data_sel=1, nzp_sel=1. Total 4 cycles.
- ir=0x41C0 (JSRR R7) -> rf_w_en=1, rf_w_addr=7, rf_r_addr_0=7, pc_data_sel=1, all in the same EXEC cycle.
- ir=0xF025 (HALT) -> HALT state after DECODE; halted=1 and all enables 0 for 20 cycles. Pulsing rst returns to FETCH with halted=0.

Source files
------------

// File: rtl/punc_control_pkg.sv
// Shared PUnC control definitions: opcodes, FSM state encodings and the
// select encodings understood by the datapath.
package punc_ctrl_defs;

   // LC3 opcodes, ir[15:12]
   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_JSR  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_RTI  = 4'b1000;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_LDI  = 4'b1010;
   localparam logic [3:0] OP_STI  = 4'b1011;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_RSV  = 4'b1101;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_HALT = 4'b1111;

   // FSM states; the encoding is visible on state_dbg
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_EXEC2  = 3'd3,
      ST_HALT   = 3'd4
   } state_e;

   // pc_data_sel
   localparam logic       PC_DATA_ADDER  = 1'b0;
   localparam logic       PC_DATA_BASE   = 1'b1;
   // pc_add_sel
   localparam logic       PC_ADD_OFF11   = 1'b0;
   localparam logic       PC_ADD_OFF9    = 1'b1;
   // mem_addr_sel
   localparam logic [1:0] MEM_ADDR_PC    = 2'd0;
   localparam logic [1:0] MEM_ADDR_ALU   = 2'd1;
   localparam logic [1:0] MEM_ADDR_STORE = 2'd2;
   // rf_w_data_sel
   localparam logic [1:0] RF_W_DATA_PC   = 2'd0;
   localparam logic [1:0] RF_W_DATA_MEM  = 2'd1;
   localparam logic [1:0] RF_W_DATA_ALU  = 2'd2;
   // alu_a_sel
   localparam logic       ALU_A_PC       = 1'b0;
   localparam logic       ALU_A_RF       = 1'b1;
   // alu_b_sel
   localparam logic       ALU_B_RF       = 1'b0;
   localparam logic       ALU_B_SEXT     = 1'b1;
   // sext_sel
   localparam logic [1:0] SEXT_5         = 2'd0;
   localparam logic [1:0] SEXT_6         = 2'd1;
   localparam logic [1:0] SEXT_9         = 2'd2;
   localparam logic [1:0] SEXT_11        = 2'd3;
   // alu_sel
   localparam logic [1:0] ALU_ADD        = 2'd0;
   localparam logic [1:0] ALU_AND        = 2'd1;
   localparam logic [1:0] ALU_NOT        = 2'd2;
   localparam logic [1:0] ALU_PASS       = 2'd3;
   // nzp_sel
   localparam logic       NZP_ALU        = 1'b0;
   localparam logic       NZP_MEM        = 1'b1;

   // Complete control word driven toward the datapath
   typedef struct packed {
      logic       pc_ld;
      logic       pc_inc;
      logic       pc_data_sel;
      logic       pc_add_sel;
      logic       ir_ld;
      logic [1:0] mem_addr_sel;
      logic       mem_w_en;
      logic       store_ld;
      logic [2:0] rf_r_addr_0;
      logic [2:0] rf_r_addr_1;
      logic [2:0] rf_w_addr;
      logic       rf_w_en;
      logic [1:0] rf_w_data_sel;
      logic       alu_a_sel;
      logic       alu_b_sel;
      logic [1:0] sext_sel;
      logic [1:0] alu_sel;
      logic       nzp_ld;
      logic       nzp_sel;
      logic       halted;
   } ctrl_t;

endpackage

// File: rtl/punc_br_eval.sv
// Branch-taken evaluation: any requested condition bit that matches a set flag.
module punc_br_eval (
   input  logic [2:0] nzp_mask,
   input  logic       n,
   input  logic       z,
   input  logic       p,
   output logic       taken
);

   // Mask bits are ordered n, z, p from msb to lsb, as in the BR encoding
   assign taken = (nzp_mask[2] & n) | (nzp_mask[1] & z) | (nzp_mask[0] & p);

endmodule

// File: rtl/punc_control.sv
// PUnC multicycle control FSM: FETCH -> DECODE -> EXEC [-> EXEC2] for the
// LC3 subset, with an absorbing HALT. Outputs depend on state and ir only.
module punc_control
   import punc_ctrl_defs::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ir,
   input  logic        n,
   input  logic        z,
   input  logic        p,
   output logic        pc_ld,
   output logic        pc_inc,
   output logic        pc_data_sel,
   output logic        pc_add_sel,
   output logic        ir_ld,
   output logic [1:0]  mem_addr_sel,
   output logic        mem_w_en,
   output logic        store_ld,
   output logic [2:0]  rf_r_addr_0,
   output logic [2:0]  rf_r_addr_1,
   output logic [2:0]  rf_w_addr,
   output logic        rf_w_en,
   output logic [1:0]  rf_w_data_sel,
   output logic        alu_a_sel,
   output logic        alu_b_sel,
   output logic [1:0]  sext_sel,
   output logic [1:0]  alu_sel,
   output logic        nzp_ld,
   output logic        nzp_sel,
   output logic        halted,
   output logic [2:0]  state_dbg
);

   state_e     state_q, state_d;
   ctrl_t      ctrl;
   logic       br_taken;
   logic [3:0] opcode;
   logic [2:0] dr, sr1, sr2;

   assign opcode = ir[15:12];
   assign dr     = ir[11:9];
   assign sr1    = ir[8:6];
   assign sr2    = ir[2:0];

   // ir[4:3] belong to the imm5 field, which the datapath extracts itself
   logic unused_ir_bits;
   assign unused_ir_bits = ^ir[4:3];

   punc_br_eval u_br_eval (
      .nzp_mask (ir[11:9]),
      .n        (n),
      .z        (z),
      .p        (p),
      .taken    (br_taken)
   );

   // State register
   always_ff @(posedge clk) begin
      // NOTE: non-blocking so every flop samples pre-edge values; the
      // synchronous reset is just the highest-priority next-state choice.
      if (rst) state_q <= ST_FETCH;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      // NOTE: default assigned first so no path leaves state_d unassigned,
      // which would otherwise infer a latch.
      state_d = ST_FETCH;
      case (state_q)
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: state_d = (opcode == OP_HALT) ? ST_HALT : ST_EXEC;
         ST_EXEC:   state_d = (opcode == OP_LDI || opcode == OP_STI) ? ST_EXEC2 : ST_FETCH;
         ST_EXEC2:  state_d = ST_FETCH;
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = ST_FETCH;   // unused encodings recover
      endcase
   end

   // Control word decode; everything is zero while rst is high
   always_comb begin
      ctrl = '0;
      if (!rst) begin
         case (state_q)
            ST_FETCH: begin
               ctrl.mem_addr_sel = MEM_ADDR_PC;
               ctrl.ir_ld        = 1'b1;
               ctrl.pc_inc       = 1'b1;
            end
            ST_EXEC: begin
               case (opcode)
                  OP_ADD, OP_AND: begin
                     ctrl.rf_r_addr_0   = sr1;
                     ctrl.rf_r_addr_1   = sr2;
                     ctrl.alu_a_sel     = ALU_A_RF;
                     ctrl.alu_b_sel     = ir[5];      // immediate mode bit
                     ctrl.sext_sel      = SEXT_5;
                     ctrl.alu_sel       = (opcode == OP_AND) ? ALU_AND : ALU_ADD;
                     ctrl.rf_w_en       = 1'b1;
                     ctrl.rf_w_addr     = dr;
                     ctrl.rf_w_data_sel = RF_W_DATA_ALU;
                     ctrl.nzp_ld        = 1'b1;
                     ctrl.nzp_sel       = NZP_ALU;
                  end
                  OP_NOT: begin
                     ctrl.rf_r_addr_0   = sr1;
                     ctrl.alu_a_sel     = ALU_A_RF;
                     ctrl.alu_sel       = ALU_NOT;
                     ctrl.rf_w_en       = 1'b1;
                     ctrl.rf_w_addr     = dr;
                     ctrl.rf_w_data_sel = RF_W_DATA_ALU;
                     ctrl.nzp_ld        = 1'b1;
                     ctrl.nzp_sel       = NZP_ALU;
                  end
                  OP_BR: begin
                     if (br_taken) begin
                        ctrl.pc_ld       = 1'b1;
                        ctrl.pc_data_sel = PC_DATA_ADDER;
                        ctrl.pc_add_sel  = PC_ADD_OFF9;
                     end
                  end
                  OP_JMP: begin
                     ctrl.rf_r_addr_0 = sr1;
                     ctrl.pc_ld       = 1'b1;
                     ctrl.pc_data_sel = PC_DATA_BASE;
                  end
                  OP_JSR: begin
                     // Link and jump share the edge; the base read sees old R7
                     ctrl.rf_w_en       = 1'b1;
                     ctrl.rf_w_addr     = 3'd7;
                     ctrl.rf_w_data_sel = RF_W_DATA_PC;
                     ctrl.pc_ld         = 1'b1;
                     if (ir[11]) begin
                        ctrl.pc_data_sel = PC_DATA_ADDER;
                        ctrl.pc_add_sel  = PC_ADD_OFF11;
                     end else begin
                        ctrl.pc_data_sel = PC_DATA_BASE;
                        ctrl.rf_r_addr_0 = sr1;
                     end
                  end
                  OP_LD, OP_LDR: begin
                     ctrl.alu_b_sel     = ALU_B_SEXT;
                     ctrl.alu_sel       = ALU_ADD;
                     ctrl.mem_addr_sel  = MEM_ADDR_ALU;
                     if (opcode == OP_LDR) begin
                        ctrl.rf_r_addr_0 = sr1;
                        ctrl.alu_a_sel   = ALU_A_RF;
                        ctrl.sext_sel    = SEXT_6;
                     end else begin
                        ctrl.alu_a_sel   = ALU_A_PC;
                        ctrl.sext_sel    = SEXT_9;
                     end
                     ctrl.rf_w_en       = 1'b1;
                     ctrl.rf_w_addr     = dr;
                     ctrl.rf_w_data_sel = RF_W_DATA_MEM;
                     ctrl.nzp_ld        = 1'b1;
                     ctrl.nzp_sel       = NZP_MEM;
                  end
                  OP_ST, OP_STR: begin
                     ctrl.alu_b_sel    = ALU_B_SEXT;
                     ctrl.alu_sel      = ALU_ADD;
                     ctrl.mem_addr_sel = MEM_ADDR_ALU;
                     if (opcode == OP_STR) begin
                        ctrl.rf_r_addr_0 = sr1;
                        ctrl.alu_a_sel   = ALU_A_RF;
                        ctrl.sext_sel    = SEXT_6;
                     end else begin
                        ctrl.alu_a_sel   = ALU_A_PC;
                        ctrl.sext_sel    = SEXT_9;
                     end
                     ctrl.rf_r_addr_1  = dr;
                     ctrl.mem_w_en     = 1'b1;
                  end
                  OP_LEA: begin
                     ctrl.alu_a_sel     = ALU_A_PC;
                     ctrl.alu_b_sel     = ALU_B_SEXT;
                     ctrl.sext_sel      = SEXT_9;
                     ctrl.alu_sel       = ALU_ADD;
                     ctrl.rf_w_en       = 1'b1;
                     ctrl.rf_w_addr     = dr;
                     ctrl.rf_w_data_sel = RF_W_DATA_ALU;
                  end
                  OP_LDI, OP_STI: begin
                     // First access fetches the pointer into the store register
                     ctrl.alu_a_sel    = ALU_A_PC;
                     ctrl.alu_b_sel    = ALU_B_SEXT;
                     ctrl.sext_sel     = SEXT_9;
                     ctrl.alu_sel      = ALU_ADD;
                     ctrl.mem_addr_sel = MEM_ADDR_ALU;
                     ctrl.store_ld     = 1'b1;
                  end
                  default: ;   // RTI and reserved opcode execute as NOP
               endcase
            end
            ST_EXEC2: begin
               ctrl.mem_addr_sel = MEM_ADDR_STORE;
               if (opcode == OP_LDI) begin
                  ctrl.rf_w_en       = 1'b1;
                  ctrl.rf_w_addr     = dr;
                  ctrl.rf_w_data_sel = RF_W_DATA_MEM;
                  ctrl.nzp_ld        = 1'b1;
                  ctrl.nzp_sel       = NZP_MEM;
               end else if (opcode == OP_STI) begin
                  ctrl.rf_r_addr_1   = dr;
                  ctrl.mem_w_en      = 1'b1;
               end
            end
            ST_HALT: ctrl.halted = 1'b1;
            default: ;   // DECODE and unused encodings drive nothing
         endcase
      end
   end

   assign pc_ld         = ctrl.pc_ld;
   assign pc_inc        = ctrl.pc_inc;
   assign pc_data_sel   = ctrl.pc_data_sel;
   assign pc_add_sel    = ctrl.pc_add_sel;
   assign ir_ld         = ctrl.ir_ld;
   assign mem_addr_sel  = ctrl.mem_addr_sel;
   assign mem_w_en      = ctrl.mem_w_en;
   assign store_ld      = ctrl.store_ld;
   assign rf_r_addr_0   = ctrl.rf_r_addr_0;
   assign rf_r_addr_1   = ctrl.rf_r_addr_1;
   assign rf_w_addr     = ctrl.rf_w_addr;
   assign rf_w_en       = ctrl.rf_w_en;
   assign rf_w_data_sel = ctrl.rf_w_data_sel;
   assign alu_a_sel     = ctrl.alu_a_sel;
   assign alu_b_sel     = ctrl.alu_b_sel;
   assign sext_sel      = ctrl.sext_sel;
   assign alu_sel       = ctrl.alu_sel;
   assign nzp_ld        = ctrl.nzp_ld;
   assign nzp_sel       = ctrl.nzp_sel;
   assign halted        = ctrl.halted;
   assign state_dbg     = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_punc_control.sv
// Bench for punc_control: directed instructions, random instruction stream,
// mid-instruction reset and HALT, each cycle compared to a behavioural model.
module tb_punc_control;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] ir;
   logic        n, z, p;
   logic        pc_ld, pc_inc, pc_data_sel, pc_add_sel, ir_ld;
   logic [1:0]  mem_addr_sel;
   logic        mem_w_en, store_ld;
   logic [2:0]  rf_r_addr_0, rf_r_addr_1, rf_w_addr;
   logic        rf_w_en;
   logic [1:0]  rf_w_data_sel;
   logic        alu_a_sel, alu_b_sel;
   logic [1:0]  sext_sel, alu_sel;
   logic        nzp_ld, nzp_sel, halted;
   logic [2:0]  state_dbg;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic       pc_ld, pc_inc, pc_data_sel, pc_add_sel, ir_ld;
      logic [1:0] mas;
      logic       mem_w_en, store_ld;
      logic [2:0] r0, r1, wa;
      logic       rf_w_en;
      logic [1:0] wds;
      logic       a_sel, b_sel;
      logic [1:0] sext, alu;
      logic       nzp_ld, nzp_sel, halted;
      logic [2:0] state;
   } outs_t;

   outs_t obs;
   assign obs = {pc_ld, pc_inc, pc_data_sel, pc_add_sel, ir_ld, mem_addr_sel,
                 mem_w_en, store_ld, rf_r_addr_0, rf_r_addr_1, rf_w_addr,
                 rf_w_en, rf_w_data_sel, alu_a_sel, alu_b_sel, sext_sel,
                 alu_sel, nzp_ld, nzp_sel, halted, state_dbg};

   punc_control dut (
      .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p),
      .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_data_sel(pc_data_sel),
      .pc_add_sel(pc_add_sel), .ir_ld(ir_ld), .mem_addr_sel(mem_addr_sel),
      .mem_w_en(mem_w_en), .store_ld(store_ld), .rf_r_addr_0(rf_r_addr_0),
      .rf_r_addr_1(rf_r_addr_1), .rf_w_addr(rf_w_addr), .rf_w_en(rf_w_en),
      .rf_w_data_sel(rf_w_data_sel), .alu_a_sel(alu_a_sel),
      .alu_b_sel(alu_b_sel), .sext_sel(sext_sel), .alu_sel(alu_sel),
      .nzp_ld(nzp_ld), .nzp_sel(nzp_sel), .halted(halted),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected outputs for one cycle, phrased as instruction semantics:
   // phase 0 fetch, 1 decode, 2 execute, 3 second memory access, 4 halted.
   function automatic outs_t model(input int phase, input logic [15:0] i,
                                   input logic fn, input logic fz, input logic fp);
      outs_t      e;
      logic [3:0] op;
      logic       addr_pc_rel, addr_base, loads_now, stores_now, taken;
      e  = '0;
      op = i[15:12];
      e.state     = 3'(phase);
      addr_pc_rel = (op == 4'h2) || (op == 4'h3) || (op == 4'hA) || (op == 4'hB);
      addr_base   = (op == 4'h6) || (op == 4'h7);
      loads_now   = (phase == 2 && (op == 4'h2 || op == 4'h6)) || (phase == 3 && op == 4'hA);
      stores_now  = (phase == 2 && (op == 4'h3 || op == 4'h7)) || (phase == 3 && op == 4'hB);
      taken       = (i[11] && fn) || (i[10] && fz) || (i[9] && fp);
      case (phase)
         0: begin e.ir_ld = 1; e.pc_inc = 1; end
         2: begin
            if (addr_pc_rel || addr_base) begin
               e.mas = 2'd1; e.b_sel = 1;       // ALU adds offset; alu = ADD
               if (addr_base) begin e.a_sel = 1; e.r0 = i[8:6]; e.sext = 2'd1; end
               else e.sext = 2'd2;
            end
            if (op == 4'hA || op == 4'hB) e.store_ld = 1;
            if (op == 4'h1 || op == 4'h5) begin
               e.r0 = i[8:6]; e.r1 = i[2:0]; e.a_sel = 1; e.b_sel = i[5];
               e.alu = (op == 4'h5) ? 2'd1 : 2'd0;
               e.rf_w_en = 1; e.wa = i[11:9]; e.wds = 2'd2; e.nzp_ld = 1;
            end
            if (op == 4'h9) begin
               e.r0 = i[8:6]; e.a_sel = 1; e.alu = 2'd2;
               e.rf_w_en = 1; e.wa = i[11:9]; e.wds = 2'd2; e.nzp_ld = 1;
            end
            if (op == 4'hE) begin
               e.b_sel = 1; e.sext = 2'd2; e.rf_w_en = 1; e.wa = i[11:9]; e.wds = 2'd2;
            end
            if (op == 4'h0 && taken) begin e.pc_ld = 1; e.pc_add_sel = 1; end
            if (op == 4'hC) begin e.r0 = i[8:6]; e.pc_ld = 1; e.pc_data_sel = 1; end
            if (op == 4'h4) begin
               e.rf_w_en = 1; e.wa = 3'd7; e.wds = 2'd0; e.pc_ld = 1;
               if (!i[11]) begin e.pc_data_sel = 1; e.r0 = i[8:6]; end
            end
         end
         3: e.mas = 2'd2;
         4: e.halted = 1;
         default: ;
      endcase
      if (loads_now) begin
         e.rf_w_en = 1; e.wa = i[11:9]; e.wds = 2'd1; e.nzp_ld = 1; e.nzp_sel = 1;
      end
      if (stores_now) begin e.r1 = i[11:9]; e.mem_w_en = 1; end
      return e;
   endfunction

   // Runs one full instruction from FETCH, checking every cycle
   task automatic run_instr(input logic [15:0] instr, input logic fn, input logic fz, input logic fp);
      int nph;
      ir = instr; n = fn; z = fz; p = fp;
      nph = (instr[15:12] == 4'hA || instr[15:12] == 4'hB) ? 4 :
            (instr[15:12] == 4'hF) ? 2 : 3;
      for (int ph = 0; ph < nph; ph++) begin
         @(negedge clk);
         check($sformatf("ir=%h nzp=%b%b%b phase%0d", instr, fn, fz, fp, ph),
               64'(obs), 64'(model(ph, instr, fn, fz, fp)));
         @(posedge clk); #1;
      end
   endtask

   // One cycle of rst high: everything must read zero
   task automatic reset_cycle(input string tag);
      rst = 1'b1;
      @(negedge clk);
      check(tag, 64'(obs), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [15:0] instr;
      rst = 1'b1; ir = 16'h1000; n = 0; z = 0; p = 0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check("reset outputs zero", 64'(obs), 64'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed instructions
      run_instr(16'h1000, 0, 0, 0);   // ADD R0,R0,R0
      run_instr(16'h1261, 0, 1, 0);   // ADD R1,R1,#1
      run_instr(16'h5A85, 1, 0, 0);   // AND R5,R2,R5
      run_instr(16'h973F, 0, 0, 1);   // NOT R3,R4
      run_instr(16'h0402, 0, 0, 1);   // BRz not taken
      run_instr(16'h0402, 0, 1, 0);   // BRz taken
      run_instr(16'h0000, 1, 1, 1);   // BR nzp=000 is NOP
      run_instr(16'hA005, 0, 0, 1);   // LDI R0
      run_instr(16'hB7FE, 1, 0, 0);   // STI R3
      run_instr(16'h41C0, 0, 1, 0);   // JSRR R7
      run_instr(16'h4FFF, 0, 1, 0);   // JSR -1
      run_instr(16'hC1C0, 0, 0, 1);   // RET
      run_instr(16'h2C10, 0, 0, 1);   // LD R6
      run_instr(16'h6A7F, 0, 0, 1);   // LDR R5,R1,#-1
      run_instr(16'hE3F0, 0, 0, 1);   // LEA R1
      run_instr(16'h3E01, 0, 0, 1);   // ST R7
      run_instr(16'h7283, 0, 0, 1);   // STR R1,R2,#3
      run_instr(16'h8000, 0, 0, 1);   // RTI as NOP
      run_instr(16'hDFFF, 0, 0, 1);   // reserved as NOP

      // Random instruction stream, HALT excluded
      for (int k = 0; k < 200; k++) begin
         do instr = 16'($urandom); while (instr[15:12] == 4'hF);
         run_instr(instr, 1'($urandom), 1'($urandom), 1'($urandom));
      end

      // Reset during EXEC of a store: no write may appear
      ir = 16'h3E01; n = 0; z = 0; p = 1;
      for (int ph = 0; ph < 2; ph++) begin
         @(negedge clk);
         check($sformatf("abort st phase%0d", ph), 64'(obs), 64'(model(ph, ir, n, z, p)));
         @(posedge clk); #1;
      end
      reset_cycle("reset mid-store");
      run_instr(16'h1261, 0, 0, 1);

      // HALT is absorbing with every enable low
      run_instr(16'hF025, 0, 0, 0);
      for (int c = 0; c < 20; c++) begin
         if (c == 7) ir = 16'h1261;   // a changing ir must not wake it
         @(negedge clk);
         check($sformatf("halt cycle %0d", c), 64'(obs), 64'(model(4, ir, n, z, p)));
         @(posedge clk); #1;
      end
      reset_cycle("reset from halt");
      run_instr(16'h1261, 0, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
